jtcontra_obj_linebuf: RTL and testbench

- Double-buffered (ping-pong) object line buffer feeding the object pixel input of the colour mixer (gfx2 path).
- Object renderer draws line N+1 into the write bank while the read bank streams line N in hdump order; each location is erased after it is read.
- Banks swap at every falling edge of LHBL.

---
 rtl/jtcontra_obj_linebuf.sv | 127 ++++++++++++
 tb/tb_jtcontra_obj_linebuf.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_obj_linebuf.sv
// Object line buffer with two banks (ping-pong) feeding the colour mixer's
// object pixel input.
// While the renderer draws line N+1 into the write bank, the read bank
// streams line N in hdump order. Each location is cleared right after it is
// read. The banks swap on every falling edge of LHBL.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   pxl_cen     - pixel clock enable (pulses at least 2 clk apart)
//   LHBL        - horizontal blank, active low
//   hdump       - read x position, sampled on pxl_cen
//   wr_addr     - renderer write x position
//   wr_data     - renderer pixel {palette[2:0], colour[3:0]}
//   wr_en       - renderer write strobe, one pixel per clk
//   line_start  - 1-clk pulse after a bank swap
//   busy        - high during the post-reset clear sweep
//   obj_pxl     - pixel to the colour mixer
module jtcontra_obj_linebuf #(
  parameter int AW = 9,
  parameter int PW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_data,
  input  logic          wr_en,
  output logic          line_start,
  output logic          busy,
  output logic [PW-1:0] obj_pxl
);

  localparam int unsigned DEPTH = 2**AW;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt;
  logic          bank;
  logic          lhbl_l;
  logic          run;
  logic          swap;
  logic          wbank;
  logic          wr_ok;
  logic          rd_now;
  logic [PW-1:0] rd_word;
  logic          erase_pend;
  logic          erase_bank;
  logic [AW-1:0] erase_addr;

  logic [PW-1:0] mem0 [DEPTH];
  logic [PW-1:0] mem1 [DEPTH];

  always_comb begin
    state_nx = state;
    if (state == ST_INIT && cnt == '1) state_nx = ST_RUN;
  end

  always_comb begin
    run    = (state == ST_RUN);
    swap   = run && lhbl_l && !LHBL;
    // A write in the swap cycle already targets the bank that becomes the
    // write bank once the swap takes effect.
    wbank  = bank ^ swap;
    wr_ok  = run && wr_en && (wr_data[3:0] != '0);
    rd_now = run && pxl_cen && LHBL;
    // Read bank is ~bank
    rd_word = bank ? mem0[hdump] : mem1[hdump];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      cnt        <= '0;
      busy       <= 1'b1;
      lhbl_l     <= 1'b1;
      bank       <= 1'b0;
      line_start <= 1'b0;
      erase_pend <= 1'b0;
      erase_bank <= 1'b0;
      erase_addr <= '0;
      obj_pxl    <= '0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx == ST_INIT);
      lhbl_l     <= LHBL;
      line_start <= swap;
      bank       <= bank ^ swap;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
      // The erase bank is captured at read time so that a swap in the
      // following clk cannot redirect the erase into the other bank.
      erase_pend <= rd_now;
      if (rd_now) begin
        erase_addr <= hdump;
        erase_bank <= ~bank;
      end
      if (!run) begin
        obj_pxl <= '0;
      end else if (pxl_cen) begin
        obj_pxl <= LHBL ? rd_word : '0;
      end
    end
  end

  // The renderer write is placed after the erase so that, should both land
  // on the same bank, fresh renderer data is not lost.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem0[cnt] <= '0;
    end else begin
      if (erase_pend && erase_bank == 1'b0) mem0[erase_addr] <= '0;
      if (wr_ok && wbank == 1'b0) mem0[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem1[cnt] <= '0;
    end else begin
      if (erase_pend && erase_bank == 1'b1) mem1[erase_addr] <= '0;
      if (wr_ok && wbank == 1'b1) mem1[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_jtcontra_obj_linebuf.sv
// Directed bench for jtcontra_obj_linebuf (AW=9, PW=7).
module tb_jtcontra_obj_linebuf;

  localparam int AW = 9;
  localparam int PW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pxl_cen = 1'b0;
  logic          LHBL = 1'b1;
  logic [AW-1:0] hdump = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          line_start;
  logic          busy;
  logic [PW-1:0] obj_pxl;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  jtcontra_obj_linebuf #(.AW(AW), .PW(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pxl_cen    (pxl_cen),
    .LHBL       (LHBL),
    .hdump      (hdump),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .line_start (line_start),
    .busy       (busy),
    .obj_pxl    (obj_pxl)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_px(input logic [AW-1:0] a, input logic [PW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick;
    wr_en   = 1'b0;
  endtask

  task automatic read_px(input string tag, input logic [AW-1:0] a,
                         input logic [PW-1:0] exp);
    hdump   = a;
    pxl_cen = 1'b1;
    tick;
    pxl_cen = 1'b0;
    check(tag, int'(obj_pxl), int'(exp));
    tick;
  endtask

  task automatic swap_line(input string tag);
    LHBL = 1'b0;
    tick;
    check({tag, "_ls_hi"}, int'(line_start), 1);
    tick;
    check({tag, "_ls_lo"}, int'(line_start), 0);
    LHBL = 1'b1;
    tick;
  endtask

  // Counts clk until busy falls while toggling LHBL and strobing writes.
  task automatic wait_init(input string tag);
    int n;
    int ls_cnt;
    n = 0;
    ls_cnt = 0;
    wr_en   = 1'b1;
    wr_addr = 9'h030;
    wr_data = 7'h55;
    while (busy === 1'b1 && n < 2000) begin
      if (n == 100) LHBL = 1'b0;
      if (n == 110) LHBL = 1'b1;
      tick;
      n++;
      if (line_start === 1'b1) ls_cnt++;
    end
    wr_en = 1'b0;
    LHBL  = 1'b1;
    check({tag, "_busy_cycles"}, n, 512);
    check({tag, "_no_line_start"}, ls_cnt, 0);
    check({tag, "_obj_zero"}, int'(obj_pxl), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", int'(busy), 1);
    check("rst_obj", int'(obj_pxl), 0);
    check("rst_line_start", int'(line_start), 0);
    tick;
    tick;
    rst_n = 1'b1;
    wait_init("init1");

    // bank=0: write bank 0, read bank 1
    read_px("first_line_rd", 9'h030, 7'h00);
    write_px(9'h010, 7'h35);
    write_px(9'h005, 7'h12);
    write_px(9'h005, 7'h40);
    write_px(9'h005, 7'h27);
    write_px(9'h006, 7'h40);
    swap_line("swap1");

    // read bank 0
    read_px("basic_rd", 9'h010, 7'h35);
    check("basic_hold", int'(obj_pxl), 'h35);
    read_px("basic_neighbour", 9'h011, 7'h00);
    read_px("overwrite", 9'h005, 7'h27);
    read_px("transparent", 9'h006, 7'h00);
    read_px("init_wr_ignored", 9'h030, 7'h00);

    // Swap with a coincident renderer write
    LHBL    = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 9'h020;
    wr_data = 7'h11;
    tick;
    wr_en = 1'b0;
    check("coll_ls", int'(line_start), 1);
    tick;
    LHBL = 1'b1;
    tick;

    // read bank 1
    read_px("coll_not_current", 9'h020, 7'h00);
    read_px("other_bank_empty", 9'h010, 7'h00);
    swap_line("swap3");

    // read bank 0 again
    read_px("erase_after_read", 9'h010, 7'h00);
    read_px("erase_addr5", 9'h005, 7'h00);
    read_px("coll_next_line", 9'h020, 7'h11);

    // pxl_cen during blank forces obj_pxl to 0
    LHBL = 1'b0;
    tick;
    check("blank_hold", int'(obj_pxl), 'h11);
    hdump   = 9'h020;
    pxl_cen = 1'b1;
    tick;
    pxl_cen = 1'b0;
    check("blank_zero", int'(obj_pxl), 0);
    tick;
    LHBL = 1'b1;
    tick;

    // read bank 1, write bank 0
    write_px(9'h040, 7'h5a);
    write_px(9'h042, 7'h66);
    swap_line("swap5");
    read_px("pre_reset_rd", 9'h040, 7'h5a);

    #2 rst_n = 1'b0;
    #1;
    check("async_obj", int'(obj_pxl), 0);
    check("async_busy", int'(busy), 1);
    tick;
    tick;
    rst_n = 1'b1;
    wait_init("init2");

    read_px("post_sweep_b1", 9'h042, 7'h00);
    swap_line("swap6");
    read_px("post_sweep_b0", 9'h042, 7'h00);
    read_px("post_sweep_b0b", 9'h040, 7'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
